// File: rtl/video_timing.sv
// Raster timing generator: free-running H/V counters, registered position decode
// (coordinates, display enable, line/frame strobes) and a delayed sync bundle for hdmi.
module video_timing #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter bit          H_POL      = 1'b1,
    parameter bit          V_POL      = 1'b1,
    parameter int unsigned CW         = 12,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic          hdmi_clk,
    input  logic          reset_n,
    output logic [2:0]    o_hve_sync,
    output logic          o_de_early,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic [15:0]   o_frame_count
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [2:0]  HVE_IDLE     = {1'b0, ~V_POL, ~H_POL};

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic [15:0]   r_frame_cnt;
    logic [2:0]    r_hve_pipe [PIPE_DELAY+1];

    logic          w_h_last;
    logic          w_v_last;
    logic          w_de;
    logic          w_hsync;
    logic          w_vsync;
    logic          w_hs_active;
    logic          w_vs_active;

    // End-of-line / end-of-frame detection
    assign w_h_last = (r_h == CW'(H_TOTAL - 1));
    assign w_v_last = (r_v == CW'(V_TOTAL - 1));

    // Combinational decode of the current counter position
    always_comb begin
        w_de        = (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACTIVE));
        w_hs_active = (r_h >= CW'(H_SYNC_START)) && (r_h < CW'(H_SYNC_END));
        w_vs_active = (r_v >= CW'(V_SYNC_START)) && (r_v < CW'(V_SYNC_END));
        w_hsync     = w_hs_active ? H_POL : ~H_POL;
        w_vsync     = w_vs_active ? V_POL : ~V_POL;
    end

    // Free-running raster counters plus completed-frame tally
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            if (w_v_last) begin
                r_v         <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_v <= r_v + CW'(1);
            end
        end else begin
            r_h <= r_h + CW'(1);
        end
    end

    // Undelayed registered outputs; frame count lags the counter wrap by one
    // cycle so it changes together with o_frame_start
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            o_x           <= '0;
            o_y           <= '0;
            o_de_early    <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_x           <= r_h;
            o_y           <= r_v;
            o_de_early    <= w_de;
            o_line_start  <= (r_h == '0);
            o_frame_start <= (r_h == '0) && (r_v == '0);
            o_frame_count <= r_frame_cnt;
        end
    end

    // Sync bundle shift line; stage 0 matches o_de_early timing
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i <= PIPE_DELAY; i++) begin
                r_hve_pipe[i] <= HVE_IDLE;
            end
        end else begin
            r_hve_pipe[0] <= {w_de, w_vsync, w_hsync};
            for (int unsigned i = 1; i <= PIPE_DELAY; i++) begin
                r_hve_pipe[i] <= r_hve_pipe[i-1];
            end
        end
    end

    assign o_hve_sync = r_hve_pipe[PIPE_DELAY];

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: three parameterisations driven from a shared clock/reset,
// checked every cycle against an arithmetic raster model indexed by edges since release.
module tb_video_timing;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        de;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
        logic [2:0]  hve;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   k = 0;          // posedges since reset release
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: default 720p timing, PIPE_DELAY=1
    logic [2:0]  a_hve;
    logic        a_de, a_ls, a_fs;
    logic [11:0] a_x, a_y;
    logic [15:0] a_fc;
    video_timing u_a (
        .hdmi_clk(clk), .reset_n(reset_n), .o_hve_sync(a_hve), .o_de_early(a_de),
        .o_x(a_x), .o_y(a_y), .o_line_start(a_ls), .o_frame_start(a_fs), .o_frame_count(a_fc)
    );

    // Instance B: tiny raster, active-low syncs, no delay
    logic [2:0]  b_hve;
    logic        b_de, b_ls, b_fs;
    logic [11:0] b_x, b_y;
    logic [15:0] b_fc;
    video_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(12), .PIPE_DELAY(0)
    ) u_b (
        .hdmi_clk(clk), .reset_n(reset_n), .o_hve_sync(b_hve), .o_de_early(b_de),
        .o_x(b_x), .o_y(b_y), .o_line_start(b_ls), .o_frame_start(b_fs), .o_frame_count(b_fc)
    );

    // Instance C: mid-size raster, PIPE_DELAY=3
    logic [2:0]  c_hve;
    logic        c_de, c_ls, c_fs;
    logic [11:0] c_x, c_y;
    logic [15:0] c_fc;
    video_timing #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .H_POL(1'b1), .V_POL(1'b1), .CW(12), .PIPE_DELAY(3)
    ) u_c (
        .hdmi_clk(clk), .reset_n(reset_n), .o_hve_sync(c_hve), .o_de_early(c_de),
        .o_x(c_x), .o_y(c_y), .o_line_start(c_ls), .o_frame_start(c_fs), .o_frame_count(c_fc)
    );

    // Expected outputs after n edges since release: edge n shows pixel index n-1 of the raster
    function automatic exp_t calc(input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input bit hp, input bit vp, input int pd, input int n);
        exp_t e;
        int ht, vt, p, q, x, y;
        bit d, hs, vs;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        e.x = '0; e.y = '0; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = '0;
        e.hve = {1'b0, ~vp, ~hp};
        if (n > 0) begin
            p = n - 1;
            x = p % ht;
            y = (p / ht) % vt;
            e.x  = 12'(x);
            e.y  = 12'(y);
            e.de = (x < ha) && (y < va);
            e.ls = (x == 0);
            e.fs = (x == 0) && (y == 0);
            e.fc = 16'(p / (ht * vt));
        end
        if (n - 1 - pd >= 0) begin
            q  = n - 1 - pd;
            x  = q % ht;
            y  = (q / ht) % vt;
            d  = (x < ha) && (y < va);
            hs = (x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
            vs = (y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
            e.hve = {d, vs, hs};
        end
        return e;
    endfunction

    task automatic chk(input string tag, input exp_t got, input exp_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            if (errors <= 20)
                $error("FAIL %s k=%0d got x=%0d y=%0d de=%b ls=%b fs=%b fc=%0d hve=%b exp x=%0d y=%0d de=%b ls=%b fs=%b fc=%0d hve=%b",
                       tag, k, got.x, got.y, got.de, got.ls, got.fs, got.fc, got.hve,
                       exp.x, exp.y, exp.de, exp.ls, exp.fs, exp.fc, exp.hve);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            if (errors <= 20) $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        chk("inst_a", {a_x, a_y, a_de, a_ls, a_fs, a_fc, a_hve},
            calc(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, 1, k));
        chk("inst_b", {b_x, b_y, b_de, b_ls, b_fs, b_fc, b_hve},
            calc(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 0, k));
        chk("inst_c", {c_x, c_y, c_de, c_ls, c_fs, c_fc, c_hve},
            calc(20, 3, 4, 5, 10, 2, 3, 4, 1'b1, 1'b1, 3, k));
    endtask

    // One clock: count the edge if out of reset, then sample on the falling edge
    task automatic step();
        @(posedge clk);
        if (reset_n) k++;
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset assertion between edges, held for n cycles
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        k = 0;
        #1;
        check_all();
        repeat (n) step();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset held with clock running
        repeat (3) step();
        chk_v("rst_hve_a", 32'(a_hve), 32'h0);
        chk_v("rst_hve_b", 32'(b_hve), 32'h3);
        chk_v("rst_fc_a", 32'(a_fc), 32'h0);
        reset_n = 1'b1;

        // First edge after release
        step();
        chk_v("first_x", 32'(a_x), 32'h0);
        chk_v("first_de", 32'(a_de), 32'h1);
        chk_v("first_fs", 32'(a_fs), 32'h1);
        chk_v("first_fc", 32'(a_fc), 32'h0);

        // Two full default lines plus a bit: de/hsync windows and the line wrap
        repeat (3400) step();
        chk_v("a_y_line2", 32'(a_y), 32'h2);

        // Mid-line reset in the default raster, 2 cycles
        repeat (500) step();
        do_reset(2);
        step();
        chk_v("rel_x", 32'(a_x), 32'h0);
        chk_v("rel_fs", 32'(a_fs), 32'h1);
        chk_v("rel_fc_c", 32'(c_fc), 32'h0);

        // Long run with sporadic random resets; B and C wrap many frames
        for (int i = 0; i < 40000; i++) begin
            step();
            if ($urandom_range(0, 3999) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        // Clean stretch to cover several C frames and B frame counts
        do_reset(2);
        repeat (97) step();
        chk_v("b_fc_97", 32'(b_fc), 32'h2);
        repeat (3000) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
